// File: rtl/countdown_scheduler_if.sv
// Request/status bundle between the game-logic FSM (master) and the countdown scheduler (slave).
interface countdown_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int CW        = 8
);
    logic                    frame_tick;
    logic [NUM_SLOTS-1:0]    start;
    logic [NUM_SLOTS*CW-1:0] seed;
    logic [NUM_SLOTS-1:0]    cancel;
    logic [NUM_SLOTS-1:0]    active;
    logic [NUM_SLOTS-1:0]    expired;
    logic                    busy;
    logic                    overrun;
    logic [NUM_SLOTS*CW-1:0] count_flat;

    modport master (
        output frame_tick, start, seed, cancel,
        input  active, expired, busy, overrun, count_flat
    );

    modport slave (
        input  frame_tick, start, seed, cancel,
        output active, expired, busy, overrun, count_flat
    );
endinterface

// File: rtl/countdown_scheduler.sv
// Time-multiplexed game countdowns: each frame tick scans all slots, one per clock,
// through a single shared decrementer.
module countdown_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int CW        = 8
) (
    input logic                  Clk,
    input logic                  Reset,
    countdown_scheduler_if.slave bus
);
    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 pending, pending_n;
    logic                 overrun_q, overrun_n;

    logic [CW-1:0]        count [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active_q;
    logic [NUM_SLOTS-1:0] expired_q;
    logic [CW-1:0]        cur_count;
    logic [CW-1:0]        dec_count;
    logic                 scanning;

    // A visit at zero expires the slot, so the decrement never has to wrap.
    function automatic logic [CW-1:0] decrement(input logic [CW-1:0] c);
        return (c == '0) ? c : c - CW'(1);
    endfunction

    assign scanning  = (state == SCAN);
    assign cur_count = count[idx];
    assign dec_count = decrement(cur_count);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pending   <= pending_n;
            overrun_q <= overrun_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending;
        overrun_n = overrun_q | (bus.frame_tick & pending);
        case (state)
            IDLE: begin
                if (bus.frame_tick || pending) begin
                    state_n   = SCAN;
                    idx_n     = '0;
                    pending_n = 1'b0;
                end
            end
            SCAN: begin
                if (bus.frame_tick) pending_n = 1'b1;
                if (idx == LAST_IDX) begin
                    idx_n = '0;
                    // A tick queued earlier in this scan chains straight into the next one.
                    if (pending) pending_n = 1'b0;
                    else         state_n   = IDLE;
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Per-slot update: start beats cancel, both beat the scan visit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) count[i] <= '0;
            active_q  <= '0;
            expired_q <= '0;
        end else begin
            expired_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.start[i]) begin
                    count[i]    <= bus.seed[i*CW +: CW];
                    active_q[i] <= 1'b1;
                end else if (bus.cancel[i]) begin
                    active_q[i] <= 1'b0;
                end else if (scanning && idx == IW'(i) && active_q[i]) begin
                    if (cur_count == '0) begin
                        active_q[i]  <= 1'b0;
                        expired_q[i] <= 1'b1;
                    end else begin
                        count[i] <= dec_count;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.count_flat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) bus.count_flat[i*CW +: CW] = count[i];
    end

    assign bus.active  = active_q;
    assign bus.expired = expired_q;
    assign bus.busy    = scanning;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_countdown_scheduler.sv
// Scoreboard bench for countdown_scheduler: a driver feeds a reference model and queues
// the expected outputs, a negedge monitor pops and compares them.
module tb_countdown_scheduler;
    localparam int NS = 4;
    localparam int CW = 8;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    countdown_scheduler_if #(.NUM_SLOTS(NS), .CW(CW)) bus ();

    countdown_scheduler #(.NUM_SLOTS(NS), .CW(CW)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NS-1:0]    active;
        logic [NS-1:0]    expired;
        logic             busy;
        logic             overrun;
        logic [NS*CW-1:0] cnt;
    } snap_t;

    snap_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: counts, flags and "visits remaining in the current scan".
    int            m_cnt [NS];
    logic [NS-1:0] m_act;
    logic [NS-1:0] m_exp;
    logic          m_ovr;
    logic          m_pend;
    int            m_left;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
        m_act  = '0;
        m_exp  = '0;
        m_ovr  = 1'b0;
        m_pend = 1'b0;
        m_left = 0;
    endtask

    task automatic model_step();
        int   v;
        logic old_pend;
        v = (m_left > 0) ? NS - m_left : -1;
        m_exp = '0;
        for (int i = 0; i < NS; i++) begin
            if (bus.start[i]) begin
                m_cnt[i] = int'(bus.seed[i*CW +: CW]);
                m_act[i] = 1'b1;
            end else if (bus.cancel[i]) begin
                m_act[i] = 1'b0;
            end else if (i == v && m_act[i]) begin
                if (m_cnt[i] == 0) begin
                    m_act[i] = 1'b0;
                    m_exp[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        old_pend = m_pend;
        if (bus.frame_tick && old_pend) m_ovr = 1'b1;
        if (m_left == 0) begin
            if (bus.frame_tick || old_pend) begin
                m_left = NS;
                m_pend = 1'b0;
            end
        end else begin
            if (bus.frame_tick) m_pend = 1'b1;
            m_left = m_left - 1;
            if (m_left == 0 && old_pend) begin
                m_left = NS;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic push_expect();
        snap_t s;
        s.active  = m_act;
        s.expired = m_exp;
        s.busy    = (m_left > 0);
        s.overrun = m_ovr;
        s.cnt     = '0;
        for (int i = 0; i < NS; i++) s.cnt[i*CW +: CW] = CW'(m_cnt[i]);
        exp_q.push_back(s);
    endtask

    // One clock: account for the edge just taken, then present the next inputs.
    task automatic cyc(input logic tk, input logic [NS-1:0] st, input logic [NS-1:0] cn,
                       input logic [NS*CW-1:0] sd, input logic rs);
        @(posedge Clk);
        #1;
        if (!Reset) model_step();
        if (rs) begin
            Reset = 1'b1;
            model_reset();
        end else begin
            Reset = 1'b0;
        end
        push_expect();
        bus.frame_tick = tk;
        bus.start      = st;
        bus.cancel     = cn;
        bus.seed       = sd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic tick_then_idle(input int n);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle(n);
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            vectors++;
            if (bus.active !== e.active) begin
                miscompares++;
                $display("FAIL active @%0t: got %b want %b", $time, bus.active, e.active);
            end
            if (bus.expired !== e.expired) begin
                miscompares++;
                $display("FAIL expired @%0t: got %b want %b", $time, bus.expired, e.expired);
            end
            if (bus.busy !== e.busy) begin
                miscompares++;
                $display("FAIL busy @%0t: got %b want %b", $time, bus.busy, e.busy);
            end
            if (bus.overrun !== e.overrun) begin
                miscompares++;
                $display("FAIL overrun @%0t: got %b want %b", $time, bus.overrun, e.overrun);
            end
            if (bus.count_flat !== e.cnt) begin
                miscompares++;
                $display("FAIL count_flat @%0t: got %h want %h", $time, bus.count_flat, e.cnt);
            end
        end
    end

    initial begin
        logic [NS-1:0]    st;
        logic [NS-1:0]    cn;
        logic [NS*CW-1:0] sd;
        logic             tk;
        logic             rs;

        bus.frame_tick = 1'b0;
        bus.start      = '0;
        bus.cancel     = '0;
        bus.seed       = '0;
        model_reset();

        // Reset state
        for (int k = 0; k < 3; k++) cyc(1'b0, '0, '0, '0, 1'b1);
        idle(2);

        // Slot 0 seed 3: three decrements then expiry on the fourth scan
        cyc(1'b0, 4'b0001, '0, {24'd0, 8'd3}, 1'b0);
        idle(2);
        for (int k = 0; k < 4; k++) tick_then_idle(19);

        // Mixed seeds across all slots
        cyc(1'b0, 4'b1111, '0, {8'd255, 8'd2, 8'd1, 8'd0}, 1'b0);
        idle(2);
        for (int k = 0; k < 3; k++) tick_then_idle(9);

        // Back-to-back scans and overrun
        cyc(1'b1, '0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, '0, 1'b0);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle(12);

        // Cancel on the expiry visit of slot 2
        cyc(1'b0, 4'b0100, '0, '0, 1'b0);
        idle(2);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle(2);
        cyc(1'b0, '0, 4'b0100, '0, 1'b0);
        idle(6);

        // Restart of slot 1 on its own visit cycle
        cyc(1'b0, 4'b0010, '0, {16'd0, 8'd5, 8'd0}, 1'b0);
        idle(2);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle(1);
        cyc(1'b0, 4'b0010, '0, {16'd0, 8'd9, 8'd0}, 1'b0);
        idle(6);

        // Reset in the second cycle of a scan
        cyc(1'b0, 4'b1111, '0, {8'd7, 8'd6, 8'd5, 8'd4}, 1'b0);
        idle(1);
        cyc(1'b1, '0, '0, '0, 1'b0);
        idle(1);
        cyc(1'b0, '0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, '0, 1'b1);
        idle(2);
        tick_then_idle(8);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tk = ($urandom_range(5) == 0);
            rs = ($urandom_range(399) == 0);
            for (int i = 0; i < NS; i++) begin
                st[i] = ($urandom_range(15) == 0);
                cn[i] = ($urandom_range(15) == 0);
                sd[i*CW +: CW] = ($urandom_range(3) == 0) ? CW'($urandom_range(255))
                                                          : CW'($urandom_range(4));
            end
            cyc(tk, st, cn, sd, rs);
        end
        idle(4);

        @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/countdown_scheduler.md
Name: countdown_scheduler

Overview:
- Time-multiplexes one shared 8-bit decrement datapath across NUM_SLOTS independent game countdowns: jetpack duration, spring boost, monster respawn and platform fade.
- On each frame tick it scans every slot in index order, one slot per clock. Each active slot is decremented, and a one-cycle expiry pulse is raised when a slot's count runs out.
- Sits between the game-logic FSM, which issues start and cancel requests, and the effect and sprite logic, which consume the active and expired flags.

Parameters:
- NUM_SLOTS, 4, number of independent countdown slots (2..8).
- CW, 8, counter width in bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; starts a scan.
- start  in  NUM_SLOTS  per-slot load request; one-cycle pulses.
- seed  in  NUM_SLOTS*CW  per-slot load values; slot i uses bits [i*CW +: CW].
- cancel  in  NUM_SLOTS  per-slot abort; one-cycle pulses.
- active  out  NUM_SLOTS  slot i is counting.
- expired  out  NUM_SLOTS  one-cycle pulse when slot i expires.
- busy  out  1  a scan is in progress.
- overrun  out  1  sticky: a frame tick was lost.
- count_flat  out  NUM_SLOTS*CW  current count of every slot (for HUD/debug).

Behaviour:
- Reset (async): all counts = 0; active = 0; expired = 0; busy = 0; overrun = 0; pending = 0; FSM = IDLE; scan index = 0.
- FSM states: IDLE, SCAN.
- IDLE -> SCAN on frame_tick, or when pending = 1 (pending is cleared on that entry). The scan index is reset to 0 on entry.
- In SCAN, one slot is visited per cycle at the current index:
  - Slot active and count != 0: count <= count - 1.
  - Slot active and count == 0: active[i] <= 0 and expired[i] pulses high on the next cycle for exactly 1 cycle; count stays 0.
  - Slot inactive: no change.
- After visiting slot NUM_SLOTS-1: return to IDLE, or rescan immediately (index back to 0) if pending = 1.
- A scan always lasts exactly NUM_SLOTS cycles. busy is high during every SCAN cycle.
- Latency: frame_tick at cycle t means slot i is visited at cycle t+1+i.
- Expiry timing: a slot loaded with seed S expires at the visit of the (S+1)th scan. Seed 0 expires on the first scan.
- A frame_tick arriving during SCAN sets pending. A frame_tick while pending is already 1 sets overrun, which is cleared only by Reset.
- start[i]: count_i <= seed_i, active[i] <= 1, taking effect the next cycle.
  - If start[i] coincides with the visit of slot i, start wins: no decrement, no expiry.
  - A start on an already-active slot restarts it.
- cancel[i]: active[i] <= 0 with no expired pulse; the count is held.
  - If start[i] and cancel[i] are asserted together, start wins.
  - If cancel[i] coincides with the expiry visit of slot i, cancel wins: no pulse.
- Requests to different slots are fully independent. Any number may be asserted in the same cycle.
- The decrement is modulo-free: count never wraps, because a visit at 0 expires the slot instead of decrementing.
- Reset asserted mid-scan aborts the scan immediately; all state returns to reset values.

Test Plan:
- Reset, then start[0] with seed 3, then one frame_tick every 20 cycles -> active[0] is 1 through scans 1-3; expired[0] pulses once at scan 4 (cycle tick+2); active[0] then 0; count_flat slot 0 reads 2,1,0,0.
- start slots 0-3 with seeds 0,1,2,255, then 3 ticks -> slot 0 expires on scan 1, slot 1 on scan 2, slot 2 on scan 3; slot 3 reads 252 and stays active.
- frame_tick, a second tick 2 cycles later, and a third 1 cycle after that -> busy high for 8 consecutive cycles (back-to-back scans); overrun = 1 and stays 1 until Reset.
- Slot 2 at count 0 and active; cancel[2] on the cycle slot 2 is visited -> no expired[2] pulse; active[2] = 0.
- Slot 1 at count 5; start[1] with seed 9 on the visit cycle of slot 1 -> count = 9 the next cycle, no decrement applied.
- Reset asserted on the 2nd cycle of a scan with slots active -> all outputs 0 asynchronously; a tick after deassertion starts a normal scan from slot 0.
